// File: rtl/dvi_ddr_serialiser.sv
// ---------------------------------------------------------------------------
// dvi_ddr_serialiser
//
// Final TMDS output stage of the DVI path. A 5-state phase ring divides
// clk_bit by five to make clk_pix, so the two clock domains are
// phase-locked by construction. Once per pixel the three TMDS symbols are
// captured into 10-bit shift registers, alongside the TMDS clock-lane word.
// Two bits per lane leave on each clk_bit cycle as rise/fall pairs for DDR
// output pads, LSB first.
//
// Ports
//   clk_bit     in   1   bit clock (126 MHz)
//   rst_n_por   in   1   asynchronous, active-low reset
//   clk_pix     out  1   pixel clock, bit 0 of the phase ring
//   sym_load    out  1   high in the clk_bit cycle whose ending edge
//                        captures tmds0..2
//   tmds0..2    in   10  TMDS symbols for lanes 0..2, launched on clk_pix
//   dvi_p_rise  out  4   P-pad bit, rising half of clk_bit (lanes 3..0)
//   dvi_p_fall  out  4   P-pad bit, falling half of clk_bit
//   dvi_n_rise  out  4   complement of dvi_p_rise
//   dvi_n_fall  out  4   complement of dvi_p_fall
// ---------------------------------------------------------------------------
module dvi_ddr_serialiser #(
    parameter logic [3:0] INVERT_LANES = 4'b0000,
    parameter logic [9:0] CLK_PATTERN  = 10'b0000011111
) (
    input  logic       clk_bit,
    input  logic       rst_n_por,
    output logic       clk_pix,
    output logic       sym_load,
    input  logic [9:0] tmds0,
    input  logic [9:0] tmds1,
    input  logic [9:0] tmds2,
    output logic [3:0] dvi_p_rise,
    output logic [3:0] dvi_p_fall,
    output logic [3:0] dvi_n_rise,
    output logic [3:0] dvi_n_fall
);

    localparam logic [4:0] RING_RESET = 5'b11100;
    localparam logic [4:0] RING_LOAD  = 5'b11001;

    logic [4:0] ring;
    logic       ring_legal;
    logic [9:0] load_word [4];
    logic [9:0] sr_p0     [4];
    logic [9:0] sr_next   [4];

    // Only the five rotations of 11100 are valid; anything else is pulled
    // back to the reset phase on the next edge.
    always_comb begin
        case (ring)
            5'b11100, 5'b01110, 5'b00111, 5'b10011, 5'b11001: ring_legal = 1'b1;
            default:                                          ring_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk_bit or negedge rst_n_por) begin
        if (!rst_n_por) begin
            ring <= RING_RESET;
        end else if (ring_legal) begin
            ring <= {ring[0], ring[4:1]};
        end else begin
            ring <= RING_RESET;
        end
    end

    // clk_pix is low for 2 cycles and high for 3; the capture edge sits
    // 3 cycles after its rising edge, where the upstream symbols are stable.
    assign clk_pix  = ring[0];
    assign sym_load = (ring == RING_LOAD);

    assign load_word[0] = tmds0;
    assign load_word[1] = tmds1;
    assign load_word[2] = tmds2;
    assign load_word[3] = CLK_PATTERN;

    // Stage p0: per-lane shift registers, loaded once per pixel, else
    // shifted right by two with zero fill.
    always_comb begin
        for (int l = 0; l < 4; l++) begin
            sr_next[l] = sym_load ? load_word[l] : {2'b00, sr_p0[l][9:2]};
        end
    end

    always_ff @(posedge clk_bit or negedge rst_n_por) begin
        if (!rst_n_por) begin
            for (int l = 0; l < 4; l++) begin
                sr_p0[l] <= '0;
            end
        end else begin
            for (int l = 0; l < 4; l++) begin
                sr_p0[l] <= sr_next[l];
            end
        end
    end

    // Stage p1: pad registers take the low bit pair of the value entering
    // the shift register, so the first pair of a new word leaves on the
    // capture edge itself. P and N are both registered to keep them
    // edge-aligned at the pads.
    always_ff @(posedge clk_bit or negedge rst_n_por) begin
        if (!rst_n_por) begin
            dvi_p_rise <= INVERT_LANES;
            dvi_p_fall <= INVERT_LANES;
            dvi_n_rise <= ~INVERT_LANES;
            dvi_n_fall <= ~INVERT_LANES;
        end else begin
            for (int l = 0; l < 4; l++) begin
                dvi_p_rise[l] <=   sr_next[l][0] ^ INVERT_LANES[l];
                dvi_p_fall[l] <=   sr_next[l][1] ^ INVERT_LANES[l];
                dvi_n_rise[l] <= ~(sr_next[l][0] ^ INVERT_LANES[l]);
                dvi_n_fall[l] <= ~(sr_next[l][1] ^ INVERT_LANES[l]);
            end
        end
    end

endmodule
